// File: rtl/param_half_adder_pkg.sv
// Shared constants for the param_half_adder datapath slice.
// Holds the legal operand-width range so datapath blocks agree on it.
package param_half_adder_pkg;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;

  function automatic bit width_legal(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/param_half_adder_ha_cell.sv
// 1-bit combinational half adder: the building block of the ripple chain.
module ha_cell (
  input  logic x,
  input  logic y,
  output logic sum,
  output logic carry
);

  assign sum   = x ^ y;
  assign carry = x & y;

endmodule

// File: rtl/param_half_adder.sv
// WIDTH-bit unsigned adder without carry-in, built from half-adder cells,
// with a registered sum/carry-out/valid stage (1-cycle latency, no backpressure).
module param_half_adder
  import param_half_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH-1:0] s_c;
  logic [WIDTH:1]   carry;
  logic             cout_c;

  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;
  logic             out_valid_d, out_valid_q;

  ha_cell u_bit0 (
    .x     (a[0]),
    .y     (b[0]),
    .sum   (s_c[0]),
    .carry (carry[1])
  );

  // Bits above 0 are full-adder slices: two half adders plus an OR of their carries.
  for (genvar i = 1; i < WIDTH; i++) begin : g_fa
    logic p;
    logic g_ab;
    logic g_pc;

    ha_cell u_ha_ab (
      .x     (a[i]),
      .y     (b[i]),
      .sum   (p),
      .carry (g_ab)
    );

    ha_cell u_ha_pc (
      .x     (p),
      .y     (carry[i]),
      .sum   (s_c[i]),
      .carry (g_pc)
    );

    assign carry[i+1] = g_ab | g_pc;
  end

  assign cout_c = carry[WIDTH];

  // Hold path keeps a/b (possibly X) out of the result when no pair is offered.
  always_comb begin
    s_d         = s_q;
    cout_d      = cout_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      s_d    = s_c;
      cout_d = cout_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign s         = s_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_param_half_adder.sv
// Bench for param_half_adder at WIDTH=1, 2 and 8: vector table, corner sequences
// and randomized traffic against an arithmetic reference model.
module tb_param_half_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v1, v2, v8;
  logic [0:0] a1, b1;
  logic [1:0] a2, b2;
  logic [7:0] a8, b8;
  logic       ov1, ov2, ov8;
  logic [0:0] s1;
  logic [1:0] s2;
  logic [7:0] s8;
  logic       c1, c2, c8;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  param_half_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1),
    .out_valid(ov1), .s(s1), .cout(c1)
  );
  param_half_adder #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .a(a2), .b(b2),
    .out_valid(ov2), .s(s2), .cout(c2)
  );
  param_half_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8),
    .out_valid(ov8), .s(s8), .cout(c8)
  );

  typedef struct {
    int         idx;   // 0: W=1, 1: W=2, 2: W=8
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
  } vec_t;

  int wid [3] = '{1, 2, 8};

  task automatic drive(input int idx, input logic v, input logic [7:0] a, input logic [7:0] b);
    case (idx)
      0: begin v1 = v; a1 = a[0:0]; b1 = b[0:0]; end
      1: begin v2 = v; a2 = a[1:0]; b2 = b[1:0]; end
      default: begin v8 = v; a8 = a; b8 = b; end
    endcase
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] es,
                       input logic ec, input logic ev);
    logic [7:0] as;
    logic       ac, av;
    case (idx)
      0: begin as = {7'b0, s1}; ac = c1; av = ov1; end
      1: begin as = {6'b0, s2}; ac = c2; av = ov2; end
      default: begin as = s8; ac = c8; av = ov8; end
    endcase
    n_vec++;
    if (as !== es || ac !== ec || av !== ev) begin
      n_bad++;
      $display("FAIL %s W=%0d: got s=%h cout=%b out_valid=%b, expected s=%h cout=%b out_valid=%b",
               name, wid[idx], as, ac, av, es, ec, ev);
    end
  endtask

  vec_t tbl [$];
  vec_t strm [$];

  logic [7:0] m_s [3];
  logic       m_c [3];
  logic       m_v [3];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Hand-derived expected results.
    tbl.push_back('{1, 8'h0, 8'h0, 8'h0, 1'b0});
    tbl.push_back('{1, 8'h1, 8'h0, 8'h1, 1'b0});
    tbl.push_back('{1, 8'h0, 8'h1, 8'h1, 1'b0});
    tbl.push_back('{1, 8'h1, 8'h1, 8'h2, 1'b0});
    tbl.push_back('{1, 8'h2, 8'h1, 8'h3, 1'b0});
    tbl.push_back('{1, 8'h1, 8'h2, 8'h3, 1'b0});
    tbl.push_back('{1, 8'h2, 8'h2, 8'h0, 1'b1});
    tbl.push_back('{1, 8'h3, 8'h3, 8'h2, 1'b1});
    tbl.push_back('{0, 8'h0, 8'h0, 8'h0, 1'b0});
    tbl.push_back('{0, 8'h0, 8'h1, 8'h1, 1'b0});
    tbl.push_back('{0, 8'h1, 8'h0, 8'h1, 1'b0});
    tbl.push_back('{0, 8'h1, 8'h1, 8'h0, 1'b1});
    tbl.push_back('{2, 8'h12, 8'h34, 8'h46, 1'b0});
    tbl.push_back('{2, 8'h80, 8'h80, 8'h00, 1'b1});
    tbl.push_back('{2, 8'h7F, 8'h01, 8'h80, 1'b0});

    strm.push_back('{2, 8'h01, 8'h02, 8'h03, 1'b0});
    strm.push_back('{2, 8'hFF, 8'h01, 8'h00, 1'b1});
    strm.push_back('{2, 8'hFF, 8'hFF, 8'hFE, 1'b1});
    strm.push_back('{2, 8'h80, 8'h7F, 8'hFF, 1'b0});
    strm.push_back('{2, 8'h00, 8'h00, 8'h00, 1'b0});
    strm.push_back('{2, 8'hAA, 8'h55, 8'hFF, 1'b0});
    strm.push_back('{2, 8'hC8, 8'h64, 8'h2C, 1'b1});
    strm.push_back('{2, 8'h0F, 8'hF1, 8'h00, 1'b1});

    // Power-on reset
    rst_n = 1'b0;
    idle_all();
    step();
    step();
    for (int k = 0; k < 3; k++) check("reset_state", k, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 3; k++) check("post_release_idle", k, 8'h00, 1'b0, 1'b0);

    // Vector table
    foreach (tbl[i]) begin
      idle_all();
      drive(tbl[i].idx, 1'b1, tbl[i].a, tbl[i].b);
      step();
      check($sformatf("table_%0d", i), tbl[i].idx, tbl[i].s, tbl[i].c, 1'b1);
    end
    idle_all();

    // Hold with X operands while idle
    drive(1, 1'b1, 8'h3, 8'h3);
    step();
    check("hold_load", 1, 8'h2, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1'b0, 8'hxx, 8'hxx);
      step();
      check($sformatf("hold_x_%0d", i), 1, 8'h2, 1'b1, 1'b0);
    end

    // Back-to-back streaming at W=8
    foreach (strm[i]) begin
      drive(2, 1'b1, strm[i].a, strm[i].b);
      step();
      check($sformatf("stream_%0d", i), 2, strm[i].s, strm[i].c, 1'b1);
    end
    idle_all();
    step();
    check("stream_drain", 2, 8'h0F + 8'hF1, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle with a result in flight
    for (int k = 0; k < 3; k++) drive(k, 1'b1, 8'h01, 8'h01);
    @(posedge clk);
    for (int k = 0; k < 3; k++) drive(k, 1'b1, 8'hFF, 8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) check("async_reset_now", k, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    step();
    for (int k = 0; k < 3; k++) check("reset_held_clocked", k, 8'h00, 1'b0, 1'b0);
    idle_all();
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 3; k++) check("release_no_valid", k, 8'h00, 1'b0, 1'b0);
    drive(2, 1'b1, 8'hFF, 8'h01);
    step();
    check("first_after_release", 2, 8'h00, 1'b1, 1'b1);
    idle_all();

    // Randomized traffic against arithmetic model
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0)
        for (int k = 0; k < 3; k++)
          check($sformatf("rand_c%0d", cyc), k, m_s[k], m_c[k], m_v[k]);
      for (int k = 0; k < 3; k++) begin
        logic       v;
        int unsigned ai, bi, sum, mask;
        mask = (1 << wid[k]) - 1;
        v  = (cyc == 0) || ($urandom_range(3) != 0);
        ai = $urandom & mask;
        bi = $urandom & mask;
        if (v) begin
          drive(k, 1'b1, ai[7:0], bi[7:0]);
          sum    = ai + bi;
          m_s[k] = 8'(sum & mask);
          m_c[k] = sum[wid[k]];
        end else begin
          drive(k, 1'b0, 8'hxx, 8'hxx);
        end
        m_v[k] = v;
      end
      step();
    end
    for (int k = 0; k < 3; k++) check("rand_last", k, m_s[k], m_c[k], m_v[k]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
